alu_seq: RTL

Multi-cycle ALU stage sitting directly upstream of the register file. It latches two 8-bit operands read from the register file, executes one operation, and produces a one-cycle write-back strobe carrying the result, destination address and 3-bit condition flags. The flags feed the register file's flag inputs; flag bit 2 is mirrored by the register file into r7. Single-cycle ops finish in one cycle; shifts and multiply iterate one step per cycle.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_comb.sv | 34 +++
 rtl/alu_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU stage.
//   op_t      - 3-bit operation codes
//   state_t   - FSM states of alu_seq
//   FLAG_*    - bit positions inside the 3-bit {C, Z, N} flag vector
//   MUL_STEPS - shift-add iterations for an 8x8 multiply
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int FLAG_C    = 2;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 0;
    localparam int MUL_STEPS = 8;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational single-cycle ops (ADD, SUB, AND, XOR, PASS).
//   op   in  operation code
//   a, b in  operands
//   y    out result
//   c    out carry (ADD) / borrow (SUB), 0 otherwise
module alu_comb
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         c
);
    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        // top bit of the widened difference is set exactly when a < b
        diff = {1'b0, a} - {1'b0, b};
        y    = b;
        c    = 1'b0;
        case (op)
            OP_ADD:  {c, y} = sum;
            OP_SUB:  {c, y} = diff;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = b;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU stage producing a one-cycle register-file write-back.
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-low reset
//   start   in  request, sampled only in IDLE together with op/a/b/dst
//   busy    out high whenever not IDLE
//   done    out one-cycle completion pulse (wr_en mirrors it)
//   result  out result, valid with done and held afterwards
//   wr_addr out latched destination address
//   flags   out {C, Z, N}, updated on completion and held otherwise
module alu_seq
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [AW-1:0] dst,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [2:0]    flags
);
    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic [2:0]      flags_q, flags_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;

    logic [W-1:0]    comb_y;
    logic            comb_c;
    logic            fin;
    logic [W-1:0]    fin_res;
    logic            fin_c;
    logic            is_shift;

    alu_comb #(.W(W)) u_comb (
        .op (op_t'(op)),
        .a  (a),
        .b  (b),
        .y  (comb_y),
        .c  (comb_c)
    );

    assign is_shift = (op == OP_SHL) || (op == OP_SHR);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flags_d   = flags_q;
        wr_addr_d = wr_addr_q;
        fin       = 1'b0;
        fin_res   = comb_y;
        fin_c     = comb_c;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op_t'(op);
                    wr_addr_d = dst;
                    if (op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = 4'(MUL_STEPS);
                        state_d  = RUN;
                    end else if (is_shift && b[2:0] != 3'd0) begin
                        acc_d   = {{W{1'b0}}, a};
                        cnt_d   = {1'b0, b[2:0]};
                        state_d = RUN;
                    end else begin
                        // shift by zero passes a through with no carry
                        fin     = 1'b1;
                        fin_res = is_shift ? a : comb_y;
                        fin_c   = is_shift ? 1'b0 : comb_c;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (op_q == OP_MUL) begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    fin_c    = |acc_d[2*W-1:W];
                end else begin
                    acc_d = (op_q == OP_SHL) ? {{W{1'b0}}, acc_q[W-2:0], 1'b0}
                                             : {{(W+1){1'b0}}, acc_q[W-1:1]};
                    fin_c = (op_q == OP_SHL) ? acc_q[W-1] : acc_q[0];
                end
                fin_res = acc_d[W-1:0];
                fin     = (cnt_d == 4'd0);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // result and flags are loaded on the edge entering DONE so they are valid with done
        if (fin) begin
            state_d         = DONE;
            result_d        = fin_res;
            flags_d[FLAG_C] = fin_c;
            flags_d[FLAG_Z] = (fin_res == '0);
            flags_d[FLAG_N] = fin_res[W-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign wr_en   = done;
    assign result  = result_q;
    assign flags   = flags_q;
    assign wr_addr = wr_addr_q;
endmodule
